// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command and response handshakes of the ALU sequencer
interface alu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs one command at a time through the ALU and returns the Z result pair
module alu_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    alu_sequencer_if.slave        bus,
    output logic [31:0]           ry_out,
    output logic [31:0]           rb_out,
    output logic [12:0]           alu_sel,
    input  logic [31:0]           alu_lo,
    input  logic [31:0]           alu_hi,
    output logic [15:0]           op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  op;
    logic [3:0]  cnt;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    logic        accept;
    logic        trap;
    logic        wide;
    logic [3:0]  cycles;

    assign accept = state == IDLE && bus.cmd_valid;
    assign trap   = bus.cmd_op > 4'd12 || (bus.cmd_op == 4'd9 && bus.cmd_a == '0);
    assign cycles = bus.cmd_op == 4'd6 ? 4'(MUL_CYCLES) : bus.cmd_op == 4'd9 ? 4'(DIV_CYCLES) : 4'd1;
    assign wide   = op == 4'd6 || op == 4'd9;

    assign bus.cmd_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_lo    = lo;
    assign bus.rsp_hi    = hi;
    assign bus.rsp_err   = err;
    assign alu_sel       = state == EXEC ? 13'd1 << op : '0;

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state: trapped commands skip the ALU entirely
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_nx = trap ? RESP : EXEC;
            EXEC:    if (cnt == 4'd1) state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, cycle counter, Z capture and completion counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ry_out   <= '0;
            rb_out   <= '0;
            op       <= '0;
            cnt      <= '0;
            lo       <= '0;
            hi       <= '0;
            err      <= 1'b0;
            op_count <= '0;
        end else begin
            if (accept) begin
                ry_out <= bus.cmd_a;
                rb_out <= bus.cmd_b;
                op     <= bus.cmd_op;
                cnt    <= cycles;
                lo     <= '0;
                hi     <= '0;
                err    <= trap;
            end else if (state == EXEC) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    lo  <= alu_lo;
                    hi  <= wide ? alu_hi : '0;
                    err <= 1'b0;
                end
            end
            if (state == RESP && bus.rsp_ready)
                op_count <= op_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with a behavioural ALU behind the sequencer
module tb_alu_sequencer;
    localparam int MUL_C = 4;
    localparam int DIV_C = 8;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        int          lat;
        int          sel_n;
        logic [12:0] sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ry_out, rb_out, alu_lo, alu_hi;
    logic [12:0] alu_sel;
    logic [15:0] op_count;
    logic [63:0] alu_res;
    logic [15:0] cnt_exp = '0;
    logic [12:0] sel_or = '0;
    int          sel_cnt = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sbq[$];

    alu_sequencer_if bus();

    alu_sequencer #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .clr(clr), .bus(bus),
        .ry_out(ry_out), .rb_out(rb_out), .alu_sel(alu_sel),
        .alu_lo(alu_lo), .alu_hi(alu_hi), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference ALU; non-wide ops leave a stale pattern on resultHi
    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            4'd0:    return {32'hDEADBEEF, a & b};
            4'd1:    return {32'hDEADBEEF, a | b};
            4'd2:    return {32'hDEADBEEF, -b};
            4'd3:    return {32'hDEADBEEF, ~b};
            4'd4:    return {32'hDEADBEEF, a - b};
            4'd5:    return {32'hDEADBEEF, a + b};
            4'd6:    return 64'(a) * 64'(b);
            4'd7:    return {32'hDEADBEEF, (a >> s) | (a << (6'd32 - {1'b0, s}))};
            4'd8:    return {32'hDEADBEEF, (a << s) | (a >> (6'd32 - {1'b0, s}))};
            4'd9:    return a == 0 ? 64'd0 : {b % a, b / a};
            4'd10:   return {32'hDEADBEEF, a >> s};
            4'd11:   return {32'hDEADBEEF, a << s};
            4'd12:   return {32'hDEADBEEF, 32'($signed(a) >>> s)};
            default: return 64'd0;
        endcase
    endfunction

    // Combinational ALU model driven by the one-hot select
    always_comb begin
        alu_res = 64'h5A5A5A5A_A5A5A5A5;
        for (int i = 0; i < 13; i++)
            if (alu_sel[i]) alu_res = alu_f(4'(i), ry_out, rb_out);
    end
    assign alu_lo = alu_res[31:0];
    assign alu_hi = alu_res[63:32];

    // Select monitor: one-hot check and per-command activity tally
    always @(negedge clk) begin
        assert ($onehot0(alu_sel)) else $error("alu_sel not one-hot: %h", alu_sel);
        if (alu_sel != '0) begin
            sel_cnt = sel_cnt + 1;
            sel_or  = sel_or | alu_sel;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] r;
        bit          bad;
        bad     = op > 4'd12 || (op == 4'd9 && a == 0);
        r       = alu_f(op, a, b);
        e.lo    = bad ? 32'd0 : r[31:0];
        e.hi    = (bad || !(op == 4'd6 || op == 4'd9)) ? 32'd0 : r[63:32];
        e.err   = bad;
        e.sel_n = bad ? 0 : op == 4'd6 ? MUL_C : op == 4'd9 ? DIV_C : 1;
        e.lat   = e.sel_n + 1;
        e.sel   = bad ? 13'd0 : 13'd1 << op;
        sbq.push_back(e);
        @(negedge clk);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        sel_cnt       = 0;
        sel_or        = '0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("ry_out", ry_out, a);
        check("rb_out", rb_out, b);
    endtask

    task automatic finish_rsp(input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sbq.pop_front();
        check("latency", lat, e.lat);
        check("rsp_lo", bus.rsp_lo, e.lo);
        check("rsp_hi", bus.rsp_hi, e.hi);
        check("rsp_err", bus.rsp_err, e.err);
        check("sel_cycles", sel_cnt, e.sel_n);
        check("sel_bits", sel_or, e.sel);
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 4'd5;
            bus.cmd_a     = 32'h1234;
            bus.cmd_b     = 32'h5678;
            @(posedge clk);
            #1;
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_ready", bus.cmd_ready, 0);
            check("hold_lo", bus.rsp_lo, e.lo);
            check("hold_hi", bus.rsp_hi, e.hi);
            check("hold_err", bus.rsp_err, e.err);
            check("hold_sel", alu_sel, 0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        cnt_exp++;
        check("op_count", op_count, cnt_exp);
        check("back_idle", bus.cmd_ready, 1);
        check("rsp_valid_drop", bus.rsp_valid, 0);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        send(op, a, b);
        finish_rsp(hold);
    endtask

    initial begin
        int acc;
        int last;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_ry", ry_out, 0);
        check("rst_rb", rb_out, 0);
        check("rst_sel", alu_sel, 0);
        check("rst_lo", bus.rsp_lo, 0);
        check("rst_hi", bus.rsp_hi, 0);
        check("rst_err", bus.rsp_err, 0);
        check("rst_count", op_count, 0);
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        clr = 1'b1;

        run_cmd(4'd5, 32'd5, 32'd7, 0);
        run_cmd(4'd6, 32'h10000, 32'h10000, 0);
        run_cmd(4'd9, 32'd0, 32'd55, 0);
        run_cmd(4'd14, 32'd1, 32'd2, 10);
        run_cmd(4'd9, 32'd7, 32'd100, 0);
        run_cmd(4'd4, 32'd3, 32'd10, 0);
        run_cmd(4'd7, 32'h8000_0001, 32'd4, 0);
        run_cmd(4'd8, 32'h8000_0001, 32'd1, 0);
        run_cmd(4'd12, 32'hF000_0000, 32'd8, 0);
        run_cmd(4'd2, 32'd0, 32'd1, 0);
        run_cmd(4'd13, 32'd9, 32'd9, 0);
        run_cmd(4'd15, 32'd9, 32'd9, 0);
        run_cmd(4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        send(4'd9, 32'd3, 32'd100);
        repeat (2) @(posedge clk);
        #1;
        check("pre_clr_sel", alu_sel, 13'h200);
        clr = 1'b0;
        #1;
        check("clr_ry", ry_out, 0);
        check("clr_rb", rb_out, 0);
        check("clr_sel", alu_sel, 0);
        check("clr_valid", bus.rsp_valid, 0);
        check("clr_lo", bus.rsp_lo, 0);
        check("clr_hi", bus.rsp_hi, 0);
        check("clr_err", bus.rsp_err, 0);
        check("clr_count", op_count, 0);
        check("clr_ready", bus.cmd_ready, 1);
        sbq.delete();
        cnt_exp = '0;
        @(negedge clk);
        clr = 1'b1;
        run_cmd(4'd3, 32'd0, 32'd0, 0);

        bus.rsp_ready = 1'b1;
        bus.cmd_op    = 4'd1;
        bus.cmd_a     = 32'h0F;
        bus.cmd_b     = 32'hF0;
        bus.cmd_valid = 1'b1;
        acc  = 0;
        last = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc++;
                if (last >= 0) check("b2b_gap", i - last, 3);
                last = i;
            end
        end
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("b2b_accepts", acc, 10);
        cnt_exp = cnt_exp + 16'd10;
        check("b2b_count", op_count, cnt_exp);

        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        cnt_exp = 16'hFFFF;
        check("preload", op_count, 16'hFFFF);
        run_cmd(4'd1, 32'h1, 32'h2, 0);
        check("wrap_zero", op_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
